div_ratio_ctrl: RTL
===================

// Module: div_ratio_ctrl
// PURPOSE
//  Programmable clock-enable divider controller for the flip-flop divider chain.
//  It generates a one-cycle tick and a divided square wave q at a run-time ratio.
//  Ratio changes arrive over a valid/ready handshake and are applied only at a
//  period boundary, so q and tick never glitch or produce a short period.
//  It sequences downstream divider stages instead of ripple-clocking them.
// PARAMETERS
//  W          8  counter and ratio width
//  RESET_DIV  1  cur_div after reset (tick period = RESET_DIV+1 cycles)
// PORTS
//  cp         in   1  clock, rising edge
//  rst        in   1  reset, synchronous, active-high
//  en         in   1  run enable; 0 freezes cnt and q
//  restart    in   1  sync phase restart (1-cycle pulse)
//  cfg_valid  in   1  new ratio offered
//  cfg_ready  out  1  controller can accept a ratio
//  cfg_div    in   W  new ratio: tick period = cfg_div+1 cycles
//  tick       out  1  one-cycle pulse per period (registered)
//  q          out  1  divided output, toggles each period
//  cnt        out  W  phase counter
//  cur_div    out  W  active ratio
//  busy       out  1  ratio change pending
// BEHAVIOUR
//  - Priority per edge: rst > restart > normal operation.
//  - Reset values: cnt=0, q=0, tick=0, cur_div=RESET_DIV, pend_div=0, state IDLE,
//    cfg_ready=1, busy=0.
//  - Wrap condition: wrap = en && (cnt == cur_div).
//  - Counting (en=1): if wrap, cnt<=0 and q<=~q; otherwise cnt<=cnt+1.
//  - Tick timing: tick<=wrap, so tick is high in the cycle where cnt reads 0 after a wrap.
//  - Resulting rates: tick every cur_div+1 cycles; q period is 2*(cur_div+1).
//    cur_div=0 gives divide-by-2; cur_div=1 gives divide-by-4.
//  - en=0: cnt and q hold, and tick<=0.
//  - FSM IDLE: cfg_ready=1 and busy=0. On cfg_valid&&cfg_ready:
//    pend_div<=cfg_div and the FSM moves to PEND.
//  - FSM PEND: cfg_ready=0 and busy=1. On wrap: cur_div<=pend_div and the FSM moves to IDLE.
//    cfg_ready rises the next cycle. The new ratio governs the cycle after the wrap.
//  - Accept in the same cycle as a wrap: the ratio is not applied at that wrap.
//    It is applied at the following wrap.
//  - PEND with en=0: the FSM stays in PEND indefinitely, and cfg_valid is ignored.
//  - restart: cnt<=0, q<=0, tick<=0. A pending ratio is applied immediately
//    (cur_div<=pend_div) and the FSM moves to IDLE.
//  - restart in IDLE: cur_div is unchanged. cfg_valid in the same cycle as restart
//    is not accepted.
//  - cnt never exceeds cur_div, because changes apply only when cnt returns to 0.
//  - Arithmetic: cnt+1 is W-bit. cfg_div=2^W-1 is legal (period 2^W).
//  - rst mid-operation: the pending ratio is discarded and all reset values are restored.
// TESTING
//  1) rst=1 for 2 cycles, then 0 -> cnt=0, q=0, tick=0, cur_div=1, cfg_ready=1.
//     With en=1: tick every 2 cycles and q period 4.
//  2) Offer cfg_div=0 at cnt=1 (cur_div=1), then en=1 -> busy=1 until wrap.
//     Afterwards tick=1 every cycle, q toggles every cycle, and cfg_ready returns.
//  3) cur_div=1, offer cfg_div=3 in the wrap cycle -> one more 2-cycle period.
//     Then 4-cycle tick spacing and q period 8, with no short q phase.
//  4) en=0 for 5 cycles mid-count with a change in PEND -> cnt, q, busy=1 held.
//     tick=0 throughout. Resume -> the change applies at the next wrap.
//  5) PEND with pend_div=7, pulse restart -> next cycle cnt=0, q=0, cur_div=7,
//     cfg_ready=1. cfg_valid during the restart cycle is not accepted.
//  6) cur_div=5, cnt=3, assert rst -> next cycle reset values and cur_div=1.
//     The pending ratio is lost.

Source files
------------

// File: rtl/div_ratio_ctrl.sv
// Programmable clock-enable divider: one-cycle tick plus a divided square wave.
// Ratio updates are handshaked in and take effect only at a period boundary.
module div_ratio_ctrl #(
   parameter int W         = 8,
   parameter int RESET_DIV = 1
) (
   input  logic         cp,
   input  logic         rst,
   input  logic         en,
   input  logic         restart,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_div,
   output logic         tick,
   output logic         q,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cur_div,
   output logic         busy
);

   typedef enum logic {
      IDLE,
      PEND
   } state_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   state_t       state, state_nxt;
   logic [W-1:0] pend_div, pend_nxt;
   logic [W-1:0] cur_nxt, cnt_nxt;
   logic         q_nxt, tick_nxt;
   logic         wrap;

   assign wrap      = en && (cnt == cur_div);
   assign cfg_ready = (state == IDLE);
   assign busy      = (state == PEND);

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend_div;
      cur_nxt   = cur_div;
      cnt_nxt   = cnt;
      q_nxt     = q;
      tick_nxt  = 1'b0;
      if (restart) begin
         // A held-off ratio is applied at once; a new offer is ignored.
         cnt_nxt   = '0;
         q_nxt     = 1'b0;
         state_nxt = IDLE;
         if (state == PEND) cur_nxt = pend_div;
      end else begin
         tick_nxt = wrap;
         if (en) begin
            if (wrap) begin
               cnt_nxt = '0;
               q_nxt   = ~q;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         unique case (state)
            IDLE: begin
               if (cfg_valid) begin
                  pend_nxt  = cfg_div;
                  state_nxt = PEND;
               end
            end
            PEND: begin
               if (wrap) begin
                  cur_nxt   = pend_div;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         state    <= IDLE;
         pend_div <= '0;
         cur_div  <= W'(RESET_DIV);
         cnt      <= '0;
         q        <= 1'b0;
         tick     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pend_div <= pend_nxt;
         cur_div  <= cur_nxt;
         cnt      <= cnt_nxt;
         q        <= q_nxt;
         tick     <= tick_nxt;
      end
   end

endmodule
